// File: rtl/ring_osc_trim_cal.sv
`default_nettype none
// ============================================================================
// Module   : ring_osc_trim_cal
// Purpose  : Binary-search trim calibration of a ring oscillator against a
//            target edge count per measurement window.
// Revision : 1.0 - initial release
// ============================================================================
module ring_osc_trim_cal #(
    parameter int WIN_CYC    = 1024,
    parameter int SETTLE_CYC = 16,
    parameter int RST_CYC    = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        start,
    input  logic        osc_div,
    input  logic [11:0] target_cnt,
    input  logic [3:0]  tol,
    output logic [25:0] trim,
    output logic        osc_reset,
    output logic [4:0]  trim_code,
    output logic        busy,
    output logic        done,
    output logic        locked
);

    localparam int MAX_AB  = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int MAX_CYC = (MAX_AB > RST_CYC) ? MAX_AB : RST_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [4:0]       CODE_MAX    = 5'd26;
    localparam logic [11:0]      CNT_MAX     = 12'hFFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_SETTLE  = 3'd2,
        S_MEASURE = 3'd3,
        S_EVAL    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [11:0]      count_q, count_d;
    logic [11:0]      tgt_q, tgt_d;
    logic [11:0]      best_err_q, best_err_d;
    logic [3:0]       tol_q, tol_d;
    logic [4:0]       lo_q, lo_d;
    logic [4:0]       hi_q, hi_d;
    logic [4:0]       code_q, code_d;
    logic [4:0]       best_code_q, best_code_d;
    logic [25:0]      trim_q, trim_d;
    logic             osc_rst_q, osc_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             locked_q, locked_d;
    logic [2:0]       sync_q;
    logic             osc_rise;

    // Thermometer: bit i set for every i below the code.
    function automatic logic [25:0] therm(input logic [4:0] k);
        logic [25:0] t;
        for (int i = 0; i < 26; i++) begin
            t[i] = (5'(i) < k);
        end
        return t;
    endfunction

    assign osc_rise = sync_q[1] & ~sync_q[2];

    logic [11:0] err;
    logic [11:0] best_err_n;
    logic [4:0]  best_code_n;
    logic [5:0]  lo_n, hi_n;
    logic [4:0]  mid_n;
    logic        too_fast, hit, hi_uflow, give_up;

    // Evaluation of the finished window; code_q holds the mid being measured.
    always_comb begin
        too_fast    = (count_q > tgt_q);
        err         = too_fast ? (count_q - tgt_q) : (tgt_q - count_q);
        hit         = (err <= {8'd0, tol_q});
        best_err_n  = best_err_q;
        best_code_n = best_code_q;
        if (err < best_err_q) begin
            best_err_n  = err;
            best_code_n = code_q;
        end
        lo_n     = {1'b0, lo_q};
        hi_n     = {1'b0, hi_q};
        hi_uflow = 1'b0;
        if (too_fast) begin
            lo_n = {1'b0, code_q} + 6'd1;
        end else if (code_q == 5'd0) begin
            hi_uflow = 1'b1;
        end else begin
            hi_n = {1'b0, code_q} - 6'd1;
        end
        give_up = hi_uflow || (lo_n > hi_n);
        mid_n   = 5'((lo_n + hi_n) >> 1);
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        count_d     = count_q;
        tgt_d       = tgt_q;
        tol_d       = tol_q;
        best_err_d  = best_err_q;
        best_code_d = best_code_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        code_d      = code_q;
        trim_d      = trim_q;
        osc_rst_d   = osc_rst_q;
        busy_d      = busy_q;
        done_d      = done_q;
        locked_d    = locked_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RST;
                    tmr_d       = '0;
                    done_d      = 1'b0;
                    locked_d    = 1'b0;
                    busy_d      = 1'b1;
                    lo_d        = 5'd0;
                    hi_d        = CODE_MAX;
                    best_err_d  = CNT_MAX;
                    best_code_d = 5'd0;
                    tgt_d       = target_cnt;
                    tol_d       = tol;
                    code_d      = CODE_MAX >> 1;
                    osc_rst_d   = 1'b1;
                end
            end
            S_RST: begin
                tmr_d = tmr_q + TMR_ONE;
                if (tmr_q == RST_LAST) begin
                    state_d   = S_SETTLE;
                    tmr_d     = '0;
                    osc_rst_d = 1'b0;
                    trim_d    = therm(code_q);
                end
            end
            S_SETTLE: begin
                count_d = '0;
                tmr_d   = tmr_q + TMR_ONE;
                if (tmr_q == SETTLE_LAST) begin
                    state_d = S_MEASURE;
                    tmr_d   = '0;
                end
            end
            S_MEASURE: begin
                // Saturate: a full count means "too fast", never a wrap to slow.
                if (osc_rise && (count_q != CNT_MAX)) begin
                    count_d = count_q + 12'd1;
                end
                tmr_d = tmr_q + TMR_ONE;
                if (tmr_q == WIN_LAST) begin
                    state_d = S_EVAL;
                    tmr_d   = '0;
                end
            end
            S_EVAL: begin
                best_err_d  = best_err_n;
                best_code_d = best_code_n;
                if (hit) begin
                    state_d  = S_DONE;
                    locked_d = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else if (give_up) begin
                    state_d  = S_DONE;
                    code_d   = best_code_n;
                    trim_d   = therm(best_code_n);
                    locked_d = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    state_d = S_SETTLE;
                    lo_d    = lo_n[4:0];
                    hi_d    = hi_n[4:0];
                    code_d  = mid_n;
                    trim_d  = therm(mid_n);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            count_q     <= '0;
            tgt_q       <= '0;
            tol_q       <= '0;
            best_err_q  <= CNT_MAX;
            best_code_q <= '0;
            lo_q        <= '0;
            hi_q        <= CODE_MAX;
            code_q      <= '0;
            trim_q      <= '0;
            osc_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            locked_q    <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            count_q     <= count_d;
            tgt_q       <= tgt_d;
            tol_q       <= tol_d;
            best_err_q  <= best_err_d;
            best_code_q <= best_code_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            code_q      <= code_d;
            trim_q      <= trim_d;
            osc_rst_q   <= osc_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            locked_q    <= locked_d;
            sync_q      <= {sync_q[1:0], osc_div};
        end
    end

    assign trim      = trim_q;
    assign osc_reset = osc_rst_q;
    assign trim_code = code_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign locked    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_trim_cal.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_osc_trim_cal
// Purpose  : Directed self-checking bench for ring_osc_trim_cal.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_osc_trim_cal;

    logic        clk = 1'b0;
    logic        resetb, start, osc_div;
    logic [11:0] target_cnt;
    logic [3:0]  tol;
    logic [25:0] trim;
    logic        osc_reset;
    logic [4:0]  trim_code;
    logic        busy, done, locked;

    logic        resetb_f, start_f, osc_f;
    logic [11:0] target_f;
    logic [3:0]  tol_f;
    logic [25:0] trim_f;
    logic        osc_reset_f;
    logic [4:0]  trim_code_f;
    logic        busy_f, done_f, locked_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ring_osc_trim_cal #(.WIN_CYC(1024), .SETTLE_CYC(16), .RST_CYC(4)) dut (
        .clk(clk), .resetb(resetb), .start(start), .osc_div(osc_div),
        .target_cnt(target_cnt), .tol(tol), .trim(trim), .osc_reset(osc_reset),
        .trim_code(trim_code), .busy(busy), .done(done), .locked(locked)
    );

    ring_osc_trim_cal #(.WIN_CYC(8192), .SETTLE_CYC(16), .RST_CYC(4)) dut_f (
        .clk(clk), .resetb(resetb_f), .start(start_f), .osc_div(osc_f),
        .target_cnt(target_f), .tol(tol_f), .trim(trim_f), .osc_reset(osc_reset_f),
        .trim_code(trim_code_f), .busy(busy_f), .done(done_f), .locked(locked_f)
    );

    // Oscillator model: after each trim change, emit 400-10*code pulses well
    // inside the following measurement window.
    logic [25:0] gen_trim = '0;
    int          gen_t    = 0;
    int          gen_n    = 400;
    initial begin
        osc_div = 1'b0;
        forever begin
            @(negedge clk);
            if (trim !== gen_trim) begin
                gen_trim = trim;
                gen_t    = 0;
                gen_n    = 400 - 10 * $countones(trim);
            end else begin
                gen_t++;
            end
            osc_div = (gen_t >= 40) && (gen_t < 40 + 2 * gen_n) && ((gen_t % 2) == 0);
        end
    end

    // Fast oscillator for the saturation instance.
    initial begin
        osc_f = 1'b0;
        forever begin
            @(negedge clk);
            osc_f = ~osc_f;
        end
    end

    // Log of codes applied to the oscillator (one entry per trim change).
    logic [4:0]  seen[$];
    logic [25:0] rec_prev = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (trim !== rec_prev) begin
                rec_prev = trim;
                seen.push_back(trim_code);
            end
        end
    end

    // First code the saturation instance moves to after its initial mid.
    logic [4:0] f_after13 = '0;
    logic       f_saw13   = 1'b0;
    logic       f_got     = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!f_got) begin
                if (trim_code_f == 5'd13) begin
                    f_saw13 = 1'b1;
                end else if (f_saw13) begin
                    f_after13 = trim_code_f;
                    f_got     = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] packed_codes();
        logic [31:0] v;
        v = '0;
        foreach (seen[i]) v = (v << 5) | 32'(seen[i]);
        return v;
    endfunction

    task automatic run_cal(input string pfx, input logic [11:0] tgt, input logic [3:0] tl,
                           input int repulse_at, output int cyc);
        target_cnt = tgt;
        tol        = tl;
        seen.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({pfx, "_busy_on"},  32'(busy),      32'd1);
        chk({pfx, "_done_clr"}, 32'(done),      32'd0);
        chk({pfx, "_mid0"},     32'(trim_code), 32'd13);
        cyc = 0;
        while ((done !== 1'b1) && (cyc < 8000)) begin
            start = (repulse_at >= 0) && ((cyc == 2) || (cyc == repulse_at));
            if (cyc == 3) chk({pfx, "_oscrst_hold"}, 32'(osc_reset), 32'd1);
            if (cyc == 4) begin
                chk({pfx, "_oscrst_rel"}, 32'(osc_reset), 32'd0);
                chk({pfx, "_trim13"},     32'(trim),      32'h0001FFF);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({pfx, "_done"},     32'(done),      32'd1);
        chk({pfx, "_busy_off"}, 32'(busy),      32'd0);
        chk({pfx, "_oscrst"},   32'(osc_reset), 32'd0);
    endtask

    initial begin
        int cyc;
        resetb     = 1'b0;
        start      = 1'b0;
        target_cnt = '0;
        tol        = '0;
        resetb_f   = 1'b0;
        start_f    = 1'b0;
        target_f   = 12'd4000;
        tol_f      = 4'd0;
        repeat (3) @(negedge clk);
        resetb   = 1'b1;
        resetb_f = 1'b1;
        @(negedge clk);

        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_done",   32'(done),      32'd0);
        chk("rst_locked", 32'(locked),    32'd0);
        chk("rst_oscrst", 32'(osc_reset), 32'd1);
        chk("rst_trim",   32'(trim),      32'd0);
        chk("rst_code",   32'(trim_code), 32'd0);

        // Saturation instance runs alongside the directed scenarios.
        start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;

        // Scenario A
        run_cal("A", 12'd300, 4'd2, -1, cyc);
        chk("A_cycles", 32'(cyc),       32'd5209);
        chk("A_locked", 32'(locked),    32'd1);
        chk("A_code",   32'(trim_code), 32'd10);
        chk("A_trim",   32'(trim),      32'h00003FF);
        chk("A_nvisit", 32'(seen.size()), 32'd5);
        chk("A_visits", packed_codes(), 32'({5'd13, 5'd6, 5'd9, 5'd11, 5'd10}));

        // Scenario E: relaunch from DONE with stray starts while busy
        run_cal("E", 12'd300, 4'd2, 600, cyc);
        chk("E_cycles", 32'(cyc),       32'd5209);
        chk("E_locked", 32'(locked),    32'd1);
        chk("E_code",   32'(trim_code), 32'd10);
        chk("E_trim",   32'(trim),      32'h00003FF);
        chk("E_visits", packed_codes(), 32'({5'd13, 5'd6, 5'd9, 5'd11, 5'd10}));

        // Scenario D: reset in the middle of the first measurement window
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("D_relaunch_done",   32'(done),   32'd0);
        chk("D_relaunch_locked", 32'(locked), 32'd0);
        repeat (220) @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        chk("D_busy",   32'(busy),      32'd0);
        chk("D_done",   32'(done),      32'd0);
        chk("D_trim",   32'(trim),      32'd0);
        chk("D_code",   32'(trim_code), 32'd0);
        chk("D_oscrst", 32'(osc_reset), 32'd1);
        repeat (3) @(negedge clk);
        chk("D_idle_oscrst", 32'(osc_reset), 32'd1);
        run_cal("D_rerun", 12'd300, 4'd2, -1, cyc);
        chk("D_rerun_code",   32'(trim_code), 32'd10);
        chk("D_rerun_locked", 32'(locked),    32'd1);

        // Scenario B: search descends to code 0 without locking
        run_cal("B", 12'd600, 4'd0, -1, cyc);
        chk("B_cycles", 32'(cyc),       32'd4168);
        chk("B_locked", 32'(locked),    32'd0);
        chk("B_code",   32'(trim_code), 32'd0);
        chk("B_trim",   32'(trim),      32'd0);
        chk("B_nvisit", 32'(seen.size()), 32'd4);
        chk("B_visits", packed_codes(), 32'({5'd13, 5'd6, 5'd2, 5'd0}));

        // Scenario C: search climbs to code 26 without locking
        run_cal("C", 12'd100, 4'd3, -1, cyc);
        chk("C_cycles", 32'(cyc),       32'd5209);
        chk("C_locked", 32'(locked),    32'd0);
        chk("C_code",   32'(trim_code), 32'd26);
        chk("C_trim",   32'(trim),      32'h3FFFFFF);
        chk("C_visits", packed_codes(), 32'({5'd13, 5'd20, 5'd23, 5'd25, 5'd26}));

        // Scenario F: saturated counts steer upward every iteration
        cyc = 0;
        while ((done_f !== 1'b1) && (cyc < 30000)) begin
            @(negedge clk);
            cyc++;
        end
        chk("F_done",   32'(done_f),      32'd1);
        chk("F_step",   32'(f_after13),   32'd20);
        chk("F_code",   32'(trim_code_f), 32'd13);
        chk("F_locked", 32'(locked_f),    32'd0);
        chk("F_trim",   32'(trim_f),      32'h0001FFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
